intra_ref_server: RTL and testbench

//  Responder side of the intra predictor's reference-sample request interface.

---
 rtl/intra_ref_server.sv | 202 ++++++++++++++++++++
 tb/tb_intra_ref_server.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra_ref_server.sv
// intra_ref_server: responder for the intra predictor's reference-sample requests.
// Holds the top-row and left-column neighbour samples of the current PU and streams
// them back eight samples per beat, top before left when both are requested.
// Optional feature macro: REF_AVAIL_EN adds one availability bit per stored sample;
// unavailable samples are output as mid-grey (1 << (BIT_DEPTH-1)).
module intra_ref_server #(
  parameter int BIT_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             PU,
  input  logic                   en_top,
  input  logic                   en_left,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [5:0]             wr_addr,
  input  logic [BIT_DEPTH-1:0]   wr_data,
  input  logic                   nb_clr,
  output logic                   ref_valid,
  output logic                   ref_side,
  output logic                   ref_last,
  output logic [8*BIT_DEPTH-1:0] ref_data,
  output logic                   busy
);

  localparam int NSAMP = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TOP  = 2'd1,
    LEFT = 2'd2
  } state_t;

  state_t               state;
  logic [2:0]           beat_cnt;
  logic [2:0]           last_idx;
  logic                 pend_top;
  logic                 pend_left;
  logic [2:0]           pu_last;
  logic                 on_last;
  logic [5:0]           rd_idx [8];
  logic [8*BIT_DEPTH-1:0] beat_data;

  logic [BIT_DEPTH-1:0] top_mem  [NSAMP];
  logic [BIT_DEPTH-1:0] left_mem [NSAMP];

`ifdef REF_AVAIL_EN
  localparam logic [BIT_DEPTH-1:0] UNAVAIL = {1'b1, {(BIT_DEPTH-1){1'b0}}};
  logic [NSAMP-1:0] top_avail;
  logic [NSAMP-1:0] left_avail;
`else
  logic unused_nb_clr;
  assign unused_nb_clr = nb_clr;
`endif

  // Index of the last beat of a side: 0/1/3/7 for 4x4 .. 32x32, codes above 3 act as 32x32
  always_comb begin
    case (PU)
      3'd0:    pu_last = 3'd0;
      3'd1:    pu_last = 3'd1;
      3'd2:    pu_last = 3'd3;
      default: pu_last = 3'd7;
    endcase
  end

  assign on_last = (beat_cnt == last_idx);
  assign busy    = (state != IDLE) | pend_top | pend_left;

  // Beat k reads samples 8k .. 8k+7 of the store being streamed
  for (genvar g = 0; g < 8; g++) begin : g_rd_idx
    assign rd_idx[g] = {beat_cnt, 3'(g)};
  end

  // Gather the eight samples of the current beat, f0 in the lowest lane
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef REF_AVAIL_EN
      if (state == LEFT)
        beat_data[i*BIT_DEPTH +: BIT_DEPTH] = left_avail[rd_idx[i]] ? left_mem[rd_idx[i]] : UNAVAIL;
      else
        beat_data[i*BIT_DEPTH +: BIT_DEPTH] = top_avail[rd_idx[i]] ? top_mem[rd_idx[i]] : UNAVAIL;
`else
      if (state == LEFT)
        beat_data[i*BIT_DEPTH +: BIT_DEPTH] = left_mem[rd_idx[i]];
      else
        beat_data[i*BIT_DEPTH +: BIT_DEPTH] = top_mem[rd_idx[i]];
`endif
    end
  end

  // Neighbour stores: writes are always accepted; a beat reading the same edge sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSAMP; i++) begin
        top_mem[i]  <= '0;
        left_mem[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_sel)
        left_mem[wr_addr] <= wr_data;
      else
        top_mem[wr_addr] <= wr_data;
    end
  end

`ifdef REF_AVAIL_EN
  // Availability bits: a write issued together with a clear still leaves its sample available
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_avail  <= '0;
      left_avail <= '0;
    end else begin
      if (nb_clr) begin
        top_avail  <= '0;
        left_avail <= '0;
      end
      if (wr_en) begin
        if (wr_sel)
          left_avail[wr_addr] <= 1'b1;
        else
          top_avail[wr_addr] <= 1'b1;
      end
    end
  end
`endif

  // Request FSM: serves top before left, merges repeats, and registers every beat output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= 3'd0;
      last_idx  <= 3'd0;
      pend_top  <= 1'b0;
      pend_left <= 1'b0;
      ref_valid <= 1'b0;
      ref_side  <= 1'b0;
      ref_last  <= 1'b0;
      ref_data  <= '0;
    end else begin
      ref_valid <= 1'b0;
      ref_side  <= 1'b0;
      ref_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_top || en_top) begin
            state     <= TOP;
            beat_cnt  <= 3'd0;
            last_idx  <= pu_last;
            pend_top  <= 1'b0;
            pend_left <= pend_left | en_left;
          end else if (pend_left || en_left) begin
            state     <= LEFT;
            beat_cnt  <= 3'd0;
            last_idx  <= pu_last;
            pend_left <= 1'b0;
          end
        end
        TOP: begin
          ref_valid <= 1'b1;
          ref_side  <= 1'b0;
          ref_last  <= on_last;
          ref_data  <= beat_data;
          if (on_last) begin
            if (pend_left || en_left) begin
              state     <= LEFT;
              beat_cnt  <= 3'd0;
              last_idx  <= pu_last;
              pend_left <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            beat_cnt  <= beat_cnt + 3'd1;
            pend_left <= pend_left | en_left;
          end
        end
        LEFT: begin
          ref_valid <= 1'b1;
          ref_side  <= 1'b1;
          ref_last  <= on_last;
          ref_data  <= beat_data;
          if (on_last) begin
            if (pend_top || en_top) begin
              state    <= TOP;
              beat_cnt <= 3'd0;
              last_idx <= pu_last;
              pend_top <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            beat_cnt <= beat_cnt + 3'd1;
            pend_top <= pend_top | en_top;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_ref_server.sv
// tb_intra_ref_server: self-checking bench for intra_ref_server.
// A sample-level model of both stores predicts every beat of every requested side.
module tb_intra_ref_server;

  localparam int BD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    PU;
  logic          en_top, en_left, wr_en, wr_sel, nb_clr;
  logic [5:0]    wr_addr;
  logic [BD-1:0] wr_data;
  logic          ref_valid, ref_side, ref_last, busy;
  logic [8*BD-1:0] ref_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        side;
    logic        last;
    logic [63:0] data;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [2:0] pu;
    bit         t;
    bit         l;
    int         exp_beats;
  } vec_t;

  beat_t got[$];
  beat_t exp_q[$];
  vec_t  vecs[10];

  logic [7:0] m_top [64];
  logic [7:0] m_left[64];
  bit         m_avail_top [64];
  bit         m_avail_left[64];

  always #5 clk = ~clk;

  intra_ref_server #(.BIT_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .PU(PU), .en_top(en_top), .en_left(en_left),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .nb_clr(nb_clr), .ref_valid(ref_valid), .ref_side(ref_side),
    .ref_last(ref_last), .ref_data(ref_data), .busy(busy)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) begin
      m_top[i] = 8'd0; m_left[i] = 8'd0;
      m_avail_top[i] = 1'b0; m_avail_left[i] = 1'b0;
    end
  endfunction

  function automatic void modelWrite(input bit s, input int a, input logic [7:0] d);
    if (s) begin m_left[a] = d; m_avail_left[a] = 1'b1; end
    else   begin m_top[a]  = d; m_avail_top[a]  = 1'b1; end
  endfunction

  function automatic logic [7:0] modelSample(input bit s, input int idx);
    logic [7:0] v;
    v = s ? m_left[idx] : m_top[idx];
`ifdef REF_AVAIL_EN
    if (!(s ? m_avail_left[idx] : m_avail_top[idx])) v = 8'd128;
`endif
    return v;
  endfunction

  function automatic logic [63:0] modelBeat(input bit s, input int k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = modelSample(s, 8*k + i);
    return r;
  endfunction

  function automatic int beatsFor(input logic [2:0] pu);
    int p;
    p = (pu > 3'd3) ? 3 : int'(pu);
    return (2 * (4 << p)) / 8;
  endfunction

  task automatic buildExpected(input logic [2:0] pu, input bit t, input bit l);
    int nb;
    beat_t b;
    nb = beatsFor(pu);
    exp_q.delete();
    if (t) for (int k = 0; k < nb; k++) begin
      b.side = 1'b0; b.last = (k == nb-1); b.data = modelBeat(1'b0, k); b.cyc = 0;
      exp_q.push_back(b);
    end
    if (l) for (int k = 0; k < nb; k++) begin
      b.side = 1'b1; b.last = (k == nb-1); b.data = modelBeat(1'b1, k); b.cyc = 0;
      exp_q.push_back(b);
    end
  endtask

  task automatic writeSample(input bit s, input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = s; wr_addr = 6'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    modelWrite(s, a, d);
  endtask

  task automatic clearAvail(input bit with_wr, input bit s, input int a, input logic [7:0] d);
    nb_clr = 1'b1; wr_en = with_wr; wr_sel = s; wr_addr = 6'(a); wr_data = d;
    @(negedge clk);
    nb_clr = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 64; i++) begin m_avail_top[i] = 1'b0; m_avail_left[i] = 1'b0; end
    if (with_wr) modelWrite(s, a, d);
  endtask

  task automatic applyStimulus(input logic [2:0] pu, input bit t, input bit l);
    PU = pu; en_top = t; en_left = l;
    @(negedge clk);
    en_top = 1'b0; en_left = 1'b0;
  endtask

  // Samples once per cycle; optional one-cycle pulses of en_top/en_left/wr_en at given cycles
  task automatic collectBeats(input int budget, input int top_at, input int left_at,
                              input int wr_at, input bit wr_s, input int wr_a, input logic [7:0] wr_d);
    int idle;
    beat_t b;
    idle = 0;
    got.delete();
    for (int c = 0; c < budget; c++) begin
      if (ref_valid) begin
        b.side = ref_side; b.last = ref_last; b.data = ref_data; b.cyc = c;
        got.push_back(b);
        idle = 0;
      end else if (got.size() > 0) begin
        idle++;
        if (idle >= 2) break;
      end
      en_top = (c == top_at); en_left = (c == left_at);
      wr_en = (c == wr_at); wr_sel = wr_s; wr_addr = 6'(wr_a); wr_data = wr_d;
      @(negedge clk);
    end
    en_top = 1'b0; en_left = 1'b0; wr_en = 1'b0;
    if (wr_at >= 0) modelWrite(wr_s, wr_a, wr_d);
  endtask

  task automatic compareStreams(input string name);
    int n;
    checkOutput({name, " beats"}, 128'(got.size()), 128'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s beat%0d {cyc,side,last,data}", name, i),
                  {got[i].cyc[7:0], got[i].side, got[i].last, got[i].data},
                  {8'(i + 1), exp_q[i].side, exp_q[i].last, exp_q[i].data});
    checkOutput({name, " idle {valid,busy}"}, {ref_valid, busy}, 2'b00);
  endtask

  initial begin
    vecs[0] = '{3'd0, 1'b1, 1'b0, 1};
    vecs[1] = '{3'd1, 1'b0, 1'b1, 2};
    vecs[2] = '{3'd2, 1'b1, 1'b0, 4};
    vecs[3] = '{3'd3, 1'b0, 1'b1, 8};
    vecs[4] = '{3'd1, 1'b1, 1'b1, 4};
    vecs[5] = '{3'd5, 1'b1, 1'b0, 8};
    vecs[6] = '{3'd7, 1'b1, 1'b1, 16};
    vecs[7] = '{3'd4, 1'b0, 1'b1, 8};
    vecs[8] = '{3'd2, 1'b1, 1'b1, 8};
    vecs[9] = '{3'd0, 1'b1, 1'b1, 2};

    rst = 1'b1; PU = 3'd0; en_top = 1'b0; en_left = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 8'd0; nb_clr = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset outputs", {ref_valid, ref_side, ref_last, busy, ref_data}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single 4x4 top beat
    for (int i = 0; i < 8; i++) writeSample(1'b0, i, 8'(i));
    buildExpected(3'd0, 1'b1, 1'b0);
    applyStimulus(3'd0, 1'b1, 1'b0);
    collectBeats(40, -1, -1, -1, 1'b0, 0, 8'd0);
    compareStreams("pu0 top");
    if (got.size() > 0) checkOutput("pu0 top data", got[0].data, 64'h0706050403020100);

    // 32x32 left column, 8 beats
    for (int i = 0; i < 64; i++) writeSample(1'b1, i, 8'(i + 64));
    buildExpected(3'd3, 1'b0, 1'b1);
    applyStimulus(3'd3, 1'b0, 1'b1);
    collectBeats(40, -1, -1, -1, 1'b0, 0, 8'd0);
    compareStreams("pu3 left");
    if (got.size() == 8) begin
      checkOutput("pu3 left first f0", got[0].data[7:0], 8'd64);
      checkOutput("pu3 left last f7", got[7].data[63:56], 8'd127);
    end

    // Table of request patterns, including PU codes above 3
    for (int i = 0; i < 64; i++) writeSample(1'b0, i, 8'($urandom));
    for (int v = 0; v < 10; v++) begin
      buildExpected(vecs[v].pu, vecs[v].t, vecs[v].l);
      applyStimulus(vecs[v].pu, vecs[v].t, vecs[v].l);
      collectBeats(40, -1, -1, -1, 1'b0, 0, 8'd0);
      checkOutput($sformatf("vec%0d beat count", v), 128'(got.size()), 128'(vecs[v].exp_beats));
      compareStreams($sformatf("vec%0d", v));
    end

    // Repeat en_top mid-stream and en_left raised mid-stream
    buildExpected(3'd2, 1'b1, 1'b1);
    applyStimulus(3'd2, 1'b1, 1'b0);
    collectBeats(40, 1, 2, -1, 1'b0, 0, 8'd0);
    compareStreams("merge mid");

    // Repeat en_top on the edge of top's last beat merges
    buildExpected(3'd2, 1'b1, 1'b0);
    applyStimulus(3'd2, 1'b1, 1'b0);
    collectBeats(40, 3, -1, -1, 1'b0, 0, 8'd0);
    compareStreams("merge last");

    // en_left on top's last-beat edge follows without a gap
    buildExpected(3'd2, 1'b1, 1'b1);
    applyStimulus(3'd2, 1'b1, 1'b0);
    collectBeats(40, -1, 3, -1, 1'b0, 0, 8'd0);
    compareStreams("left at last");

    // Write colliding with the beat that reads the same address
    writeSample(1'b0, 8, 8'h11);
    buildExpected(3'd1, 1'b1, 1'b0);
    applyStimulus(3'd1, 1'b1, 1'b0);
    collectBeats(40, -1, -1, 1, 1'b0, 8, 8'h22);
    compareStreams("collision");
    if (got.size() > 1) checkOutput("collision old value", got[1].data[7:0], 8'h11);
    buildExpected(3'd1, 1'b1, 1'b0);
    applyStimulus(3'd1, 1'b1, 1'b0);
    collectBeats(40, -1, -1, -1, 1'b0, 0, 8'd0);
    compareStreams("after collision");
    if (got.size() > 1) checkOutput("new value visible", got[1].data[7:0], 8'h22);

    // Availability: clear, then write only top[0]
    clearAvail(1'b0, 1'b0, 0, 8'd0);
    writeSample(1'b0, 0, 8'd9);
    buildExpected(3'd0, 1'b1, 1'b0);
    applyStimulus(3'd0, 1'b1, 1'b0);
    collectBeats(40, -1, -1, -1, 1'b0, 0, 8'd0);
    compareStreams("avail");
`ifdef REF_AVAIL_EN
    if (got.size() > 0) checkOutput("avail data", got[0].data, 64'h8080808080808009);
`endif
    clearAvail(1'b1, 1'b0, 1, 8'd5);
    buildExpected(3'd0, 1'b1, 1'b0);
    applyStimulus(3'd0, 1'b1, 1'b0);
    collectBeats(40, -1, -1, -1, 1'b0, 0, 8'd0);
    compareStreams("clear with write");

    // Randomized requests against the model
    for (int it = 0; it < 25; it++) begin
      logic [2:0] pu;
      bit t, l;
      int nb, tat, lat;
      if ($urandom_range(0, 3) == 0) clearAvail(1'b0, 1'b0, 0, 8'd0);
      repeat ($urandom_range(1, 12))
        writeSample(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 8'($urandom));
      pu = 3'($urandom_range(0, 7));
      t = 1'($urandom_range(0, 1));
      l = t ? 1'($urandom_range(0, 1)) : 1'b1;
      nb = beatsFor(pu);
      tat = -1; lat = -1;
      if (t) begin
        if ($urandom_range(0, 1) == 1) tat = int'($urandom_range(0, nb - 1));
        if (!l && $urandom_range(0, 1) == 1) lat = int'($urandom_range(0, nb - 1));
      end
      buildExpected(pu, t, l || (lat >= 0));
      applyStimulus(pu, t, l);
      collectBeats(40, tat, lat, -1, 1'b0, 0, 8'd0);
      compareStreams($sformatf("rand%0d", it));
    end

    // Reset during beat 3 of a 32x32 stream with left pending
    applyStimulus(3'd3, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("pre-reset beat valid", {ref_valid, ref_side}, 2'b10);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid-stream reset outputs", {ref_valid, ref_side, ref_last, busy, ref_data}, '0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (ref_valid) seen++;
      end
      checkOutput("no beats after reset", 128'(seen), 128'(0));
    end
    buildExpected(3'd1, 1'b1, 1'b1);
    applyStimulus(3'd1, 1'b1, 1'b1);
    collectBeats(40, -1, -1, -1, 1'b0, 0, 8'd0);
    compareStreams("after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
